// File: rtl/jtkcpu_pshpul_pkg.sv
// jtkcpu_pshpul_pkg: sequencer state encoding and postbyte register bit positions
package jtkcpu_pshpul_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PDEC = 3'd1,
        PWR  = 3'd2,
        PRD  = 3'd3,
        PLD  = 3'd4,
        DONE = 3'd5
    } pshpul_state_t;

    localparam int CCBIT = 0;
    localparam int ABIT  = 1;
    localparam int BBIT  = 2;
    localparam int DPBIT = 3;
    localparam int XBIT  = 4;
    localparam int YBIT  = 5;
    localparam int UBIT  = 6;
    localparam int PCBIT = 7;

endpackage

// File: rtl/jtkcpu_pshpul.sv
// jtkcpu_pshpul: walks the postbyte mask, issuing one stack write/read per byte
module jtkcpu_pshpul
    import jtkcpu_pshpul_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       psh_go,
    input  logic       pul_go,
    input  logic [7:0] postbyte,
    input  logic       us_sel,
    input  logic       mem_ack,
    output logic [7:0] psh_sel,
    output logic       psh_hilon,
    output logic       psh_ussel,
    output logic       pshdec,
    output logic       pul_en,
    output logic       mem_we,
    output logic       mem_rd,
    output logic       busy,
    output logic       done
);

    pshpul_state_t state_q, state_d;
    logic [7:0]    mask_q, mask_d;
    logic [7:0]    sel_q, sel_d;
    logic          dir_q, dir_d;
    logic          hilon_q, hilon_d;
    logic          ussel_q, ussel_d;

    // Push takes the highest set bit, pull the lowest
    function automatic logic [7:0] pick(input logic [7:0] m, input logic push);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (push ? m[i] : m[7-i]) r = push ? (8'd1 << i) : (8'd1 << (7 - i));
        end
        return r;
    endfunction

    function automatic logic is16(input logic [7:0] s);
        return |s[PCBIT:XBIT];
    endfunction

    // Next-state: start latch in IDLE, byte advance after a write ack or a load
    always_comb begin
        logic [7:0] nmask, nsel, gsel;
        logic       adv;
        state_d = state_q;
        mask_d  = mask_q;
        sel_d   = sel_q;
        dir_d   = dir_q;
        hilon_d = hilon_q;
        ussel_d = ussel_q;
        nmask   = mask_q & ~sel_q;
        nsel    = pick(nmask, dir_q);
        gsel    = pick(postbyte, psh_go);
        adv     = 1'b0;
        case (state_q)
            IDLE: if (psh_go || pul_go) begin
                dir_d   = psh_go;
                mask_d  = postbyte;
                ussel_d = us_sel;
                sel_d   = gsel;
                hilon_d = !psh_go && is16(gsel);
                state_d = postbyte == 8'd0 ? DONE : (psh_go ? PDEC : PRD);
            end
            PDEC:    state_d = PWR;
            PWR:     adv = mem_ack;
            PRD:     state_d = mem_ack ? PLD : PRD;
            PLD:     adv = 1'b1;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // hilon differs from dir only while the first byte of a 16-bit register is in flight
        if (adv) begin
            if (is16(sel_q) && (hilon_q ^ dir_q)) begin
                hilon_d = !hilon_q;
                state_d = dir_q ? PDEC : PRD;
            end else begin
                mask_d  = nmask;
                sel_d   = nsel;
                hilon_d = !dir_q && is16(nsel);
                state_d = nmask == 8'd0 ? DONE : (dir_q ? PDEC : PRD);
            end
        end
    end

    // State register, advancing only on clock enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            sel_q   <= '0;
            dir_q   <= 1'b0;
            hilon_q <= 1'b0;
            ussel_q <= 1'b0;
        end else if (cen) begin
            state_q <= state_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
            dir_q   <= dir_d;
            hilon_q <= hilon_d;
            ussel_q <= ussel_d;
        end
    end

    assign psh_sel   = sel_q;
    assign psh_hilon = hilon_q;
    assign psh_ussel = ussel_q;
    assign pshdec    = state_q == PDEC;
    assign mem_we    = state_q == PWR;
    assign mem_rd    = state_q == PRD;
    assign pul_en    = state_q == PLD;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;

endmodule
